// File: rtl/dispatch_fetch_buffer.sv
// dispatch_fetch_buffer: in-order circular instruction buffer between fetch
// and an N-wide dispatch stage. Fetch groups are compacted and written at the
// tail. The oldest WIDTH entries are presented to dispatch and retired as the
// unstalled prefix. A WFI fence halts enqueue until squash.
// Optional feature macro: DISPATCH_BUF_BYPASS_EN (0-cycle empty-buffer bypass).

`ifndef WFI
`define WFI 32'h10500073
`endif

package dispatch_fetch_buffer_pkg;
    localparam logic [31:0] WFI_INST  = `WFI;
    localparam logic [31:0] ADDI_BASE = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } IF_ID_PACKET;
endpackage

module dispatch_fetch_buffer
    import dispatch_fetch_buffer_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  IF_ID_PACKET [WIDTH-1:0]       if_packet,
    output logic                          buf_ready,
    output IF_ID_PACKET [WIDTH-1:0]       dis_packet,
    input  logic [WIDTH-1:0]              d_stall,
    output logic [$clog2(WIDTH+1)-1:0]    dis_count,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic                          halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(WIDTH+1);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t          state;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    IF_ID_PACKET     mem [DEPTH];

    IF_ID_PACKET [WIDTH-1:0] comp;
    IF_ID_PACKET [WIDTH-1:0] wr_pkt;
    logic [NW-1:0]           enq_n;
    logic                    wfi_hit;
    logic                    enq_en;
    logic                    bypass_act;
    logic [NW-1:0]           deq_buf;
    logic [NW-1:0]           wr_n;
    logic [NW-1:0]           wr_start;

    assign buf_ready = (state == RUN) && ((CW'(DEPTH) - count) >= CW'(WIDTH));
    assign enq_en    = buf_ready && !squash;
    assign occupancy = count;

`ifdef DISPATCH_BUF_BYPASS_EN
    assign bypass_act = (count == '0) && (state == RUN) && !squash;
`else
    assign bypass_act = 1'b0;
`endif

    // Compact valid fetch slots in order; anything younger than a WFI is dropped
    always_comb begin
        int n;
        comp    = '0;
        wfi_hit = 1'b0;
        n       = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (if_packet[i].valid && !wfi_hit) begin
                comp[n] = if_packet[i];
                n       = n + 1;
                if (if_packet[i].inst == WFI_INST)
                    wfi_hit = 1'b1;
            end
        end
        enq_n = NW'(n);
    end

    // Present the oldest entries (or the bypassed group when empty)
    always_comb begin
        dis_packet = '0;
        if (!squash) begin
            if (bypass_act) begin
                dis_packet = comp;
            end else begin
                for (int i = 0; i < WIDTH; i++)
                    if (CW'(i) < count)
                        dis_packet[i] = mem[PW'(int'(head) + i)];
            end
        end
    end

    // In-order handshake: consumed slots form the valid, unstalled prefix
    always_comb begin
        logic ok;
        int   n;
        ok = 1'b1;
        n  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ok && dis_packet[i].valid && !d_stall[i])
                n = n + 1;
            else
                ok = 1'b0;
        end
        dis_count = NW'(n);
    end

    // Split consumption between stored entries and the bypassed group
    always_comb begin
        deq_buf  = bypass_act ? '0 : dis_count;
        wr_start = bypass_act ? dis_count : '0;
        wr_n     = enq_en ? (enq_n - wr_start) : '0;
    end

    // Align the unconsumed part of the compacted group to the tail
    always_comb begin
        wr_pkt = '0;
        for (int k = 0; k < WIDTH; k++)
            for (int j = 0; j < WIDTH; j++)
                if (j == k + int'(wr_start))
                    wr_pkt[k] = comp[j];
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clock) begin
        for (int k = 0; k < WIDTH; k++)
            if (NW'(k) < wr_n)
                mem[PW'(int'(tail) + k)] <= wr_pkt[k];
    end

    // Pointers, count and halt FSM; squash wins over enqueue and dequeue
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            state  <= RUN;
            halted <= 1'b0;
        end else if (squash) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            head  <= head + PW'(deq_buf);
            tail  <= tail + PW'(wr_n);
            count <= count + CW'(wr_n) - CW'(deq_buf);
            case (state)
                RUN: begin
                    if (enq_en && wfi_hit) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_fetch_buffer.sv
// Scoreboard bench for dispatch_fetch_buffer: enqueued packets are pushed to a
// queue, dispatched packets are popped and compared in order.
module tb_dispatch_fetch_buffer;
    import dispatch_fetch_buffer_pkg::*;

    localparam int W = 3;
    localparam int D = 16;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  squash = 1'b0;
    IF_ID_PACKET [W-1:0]   if_packet;
    logic                  buf_ready;
    IF_ID_PACKET [W-1:0]   dis_packet;
    logic [W-1:0]          d_stall;
    logic [1:0]            dis_count;
    logic [4:0]            occupancy;
    logic                  halted;

    int          n_chk = 0;
    int          n_pass = 0;
    IF_ID_PACKET sbq[$];
    int          mcount = 0;
    bit          mhalt = 1'b0;
    int          pc_seq = 0;

    dispatch_fetch_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .if_packet  (if_packet),
        .buf_ready  (buf_ready),
        .dis_packet (dis_packet),
        .d_stall    (d_stall),
        .dis_count  (dis_count),
        .occupancy  (occupancy),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Build a fetch group; wfi_slot < 0 means no WFI
    task automatic set_grp(input logic [W-1:0] vmask, input int wfi_slot);
        logic [31:0] s;
        for (int i = 0; i < W; i++) begin
            if_packet[i] = '0;
            if (vmask[i]) begin
                pc_seq++;
                s = pc_seq;
                if_packet[i].valid = 1'b1;
                if_packet[i].pc    = s << 2;
                if_packet[i].inst  = (i == wfi_slot) ? WFI_INST : (ADDI_BASE | {s[11:0], 20'h0});
            end
        end
    endtask

    // One cycle: inputs already driven; check mid-cycle, update model, advance
    task automatic cyc();
        int  avail, exp_dis, nenq;
        bit  ok, mready, stop;
        #4;
        mready = !mhalt && (D - mcount >= W);
        chk("buf_ready", buf_ready, mready);
        chk("occupancy", occupancy, mcount);
        chk("halted", halted, mhalt);
        avail = squash ? 0 : mcount;
        nenq = 0;
        stop = 1'b0;
        if (mready && !squash) begin
            for (int i = 0; i < W; i++) begin
                if (if_packet[i].valid && !stop) begin
                    sbq.push_back(if_packet[i]);
                    nenq++;
                    if (if_packet[i].inst == WFI_INST) stop = 1'b1;
                end
            end
        end
`ifdef DISPATCH_BUF_BYPASS_EN
        if (!squash && mcount == 0 && !mhalt) avail = nenq;
`endif
        exp_dis = 0;
        ok = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (ok && i < avail && !d_stall[i]) exp_dis++;
            else ok = 1'b0;
        end
        chk("dis_count", dis_count, exp_dis);
        for (int i = 0; i < W; i++) begin
            if (i < avail) chk($sformatf("dis_packet%0d", i), dis_packet[i], sbq[i]);
            else           chk($sformatf("dis_valid%0d", i), dis_packet[i].valid, 1'b0);
        end
        for (int i = 0; i < exp_dis; i++) void'(sbq.pop_front());
        if (squash) begin
            sbq.delete();
            mcount = 0;
            mhalt  = 1'b0;
        end else begin
            mcount = mcount + nenq - exp_dis;
            if (stop) mhalt = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        if_packet = '0;
        d_stall   = '0;
        #12;
        // reset state
        chk("rst_ready", buf_ready, 1'b1);
        chk("rst_occ", occupancy, 0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_dis_count", dis_count, 0);
        chk("rst_dis_packet", dis_packet, '0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // full group, no stall
        set_grp(3'b111, -1); cyc();
        if_packet = '0; cyc(); cyc();

        // sparse group 101
        set_grp(3'b101, -1); cyc();
        if_packet = '0; d_stall = 3'b111;
        #4 chk("sparse_v", {dis_packet[2].valid, dis_packet[1].valid, dis_packet[0].valid}, 3'b011);
        #0; cyc_partial_fix();
        d_stall = '0; cyc();

        // 6 entries, stall 010 blocks younger slots
        d_stall = 3'b111;
        set_grp(3'b111, -1); cyc();
        set_grp(3'b111, -1); cyc();
        if_packet = '0; d_stall = 3'b010; cyc();
        d_stall = 3'b111; cyc();
        chk("stall_occ", occupancy, 5);

        // fill to 14, held group ignored, drain one frees space next cycle
        while (mcount < 14) begin set_grp(3'b111, -1); cyc(); end
        cyc(); cyc();
        d_stall = 3'b110; cyc();
        d_stall = 3'b111; cyc();
        if_packet = '0;

        // 20 random groups across the wrap
        for (int g = 0; g < 20; g++) begin
            set_grp(3'($urandom_range(0, 7)), -1);
            d_stall = 3'($urandom_range(0, 7));
            cyc();
        end
        if_packet = '0; d_stall = '0;
        repeat (8) cyc();

        // WFI fence
        set_grp(3'b111, 1); cyc();
        if_packet = '0; d_stall = 3'b111; cyc();
        set_grp(3'b111, -1); cyc();
        if_packet = '0; d_stall = '0; repeat (2) cyc();
        squash = 1'b1; cyc();
        squash = 1'b0; cyc();

        // squash with enqueue on non-empty buffer
        d_stall = 3'b111;
        set_grp(3'b111, -1); cyc();
        set_grp(3'b011, -1); cyc();
        squash = 1'b1; set_grp(3'b111, -1); d_stall = '0; cyc();
        squash = 1'b0; if_packet = '0; cyc();

        // enqueue into empty buffer (same-cycle dispatch only with bypass)
        set_grp(3'b111, -1); cyc();
        if_packet = '0; repeat (2) cyc();

        // asynchronous reset mid-operation
        d_stall = 3'b111;
        set_grp(3'b111, -1); cyc();
        if_packet = '0; cyc();
        #2 reset = 1'b0;
        #1;
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_valid", dis_packet[0].valid, 1'b0);
        sbq.delete(); mcount = 0; mhalt = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1; d_stall = '0;
        set_grp(3'b110, -1); cyc();
        if_packet = '0; repeat (2) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Completes a cycle whose mid-point was already reached by an explicit check
    task automatic cyc_partial_fix();
        #(-0);
        @(posedge clock);
        #1;
        // the skipped model update: 2 entries held, nothing consumed
        chk("sparse_occ", occupancy, 2);
        chk("sparse_pk0", dis_packet[0], sbq[0]);
        chk("sparse_pk1", dis_packet[1], sbq[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", n_chk, -1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dispatch_fetch_buffer.md
# dispatch_fetch_buffer

Parametrised in-order instruction buffer between fetch and the N-wide dispatch stage. It accepts up to WIDTH `IF_ID_PACKET`s per cycle from fetch and stores them in a circular queue. It presents the oldest WIDTH entries to dispatch and retires them in order according to the per-slot structural stall vector from dispatch. It also tracks a halt (WFI) fence and supports full squash on branch recovery.

## Interface
- WIDTH, 3, fetch/dispatch slots per cycle; slot 0 is oldest.
- DEPTH, 16, queue entries; power of two, DEPTH >= 2*WIDTH.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- squash  in  1  flush all entries (mispredict / precise-state recovery).
- if_packet  in  IF_ID_PACKET[WIDTH-1:0]  fetched group; `.valid` per slot, valid slots need not be contiguous.
- buf_ready  out  1  buffer will accept a full group this cycle.
- dis_packet  out  IF_ID_PACKET[WIDTH-1:0]  oldest entries; `.valid`=0 on empty slots.
- d_stall  in  WIDTH  per-slot structural stall from dispatch.
- dis_count  out  $clog2(WIDTH+1)  number of entries consumed this cycle.
- occupancy  out  $clog2(DEPTH+1)  registered entry count.
- halted  out  1  FSM in HALTED.

## Operation
- Storage: DEPTH-entry array, head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH, separate count register 0..DEPTH.
- dis_packet[i] = entry[head+i] if i < count, else all-zero packet.
- Dispatch handshake, in order: slot i is consumed iff dis_packet[i].valid and d_stall[j]==0 for all j<=i. dis_count = length of that prefix. A stalled slot blocks all younger slots even if they are unstalled.
- Enqueue when buf_ready and not squash. Valid if_packet slots are compacted in slot order and written at tail.
- buf_ready = (state==RUN) && (DEPTH-count >= WIDTH). It is computed from registers only, with no dependency on d_stall.
- FSM states:
  - RUN: normal operation.
  - HALTED: entered when an enqueued valid slot has inst == `WFI`. The WFI entry is written. Valid slots younger than it in the same group are dropped. Enqueue is blocked; draining continues.
  - HALTED → RUN only on squash.
- Next state: head += dis_count, tail += enq_count, count += enq_count - dis_count.
- Squash has priority over enqueue and dequeue. On squash, head=tail=count=0 and state=RUN. dis_packet valids and dis_count are forced to 0 in the squash cycle.

## Timing
- Reset (async assert): head=tail=count=0, state=RUN, buf_ready=1, dis_packet all zero, dis_count=0, occupancy=0, halted=0.
- Enqueue-to-visible latency is 1 cycle (bypass off). Dispatch-to-free takes effect on the next edge.
- Simultaneous enqueue and dequeue in the same cycle are legal. When full, a dequeue frees space one cycle later, because buf_ready is registered-count based.
- Full (count > DEPTH-WIDTH): buf_ready=0, and fetch must hold its group. Empty: all dis_packet valids are 0 and dis_count=0.
- Pointer wrap is seamless: a group spanning index DEPTH-1 → 0 is written and read contiguously in logical order.
- Reset asserted mid-operation discards all contents immediately.

## Configuration
- `DISPATCH_BUF_BYPASS_EN`:
  - Defined: when count==0, state==RUN and not squash, compacted incoming valid packets drive dis_packet in the same cycle (0-cycle latency).
  - Under bypass, entries consumed per the handshake are not written; the unconsumed remainder is written at tail.
  - A bypassed WFI still moves the FSM to HALTED.
  - Undefined: no bypass; minimum latency is 1 cycle.

## Test plan
- Reset, then enqueue 3 valid ADDIs with d_stall=000 → next cycle dis_packet valid=111, dis_count=3; following cycle occupancy=0.
- Enqueue sparse group with valids 101 → next cycle dis_packet[0],[1] hold the original slots 0 and 2, slot 2 invalid, occupancy=2.
- With 6 entries buffered and d_stall=010 → dis_count=1, occupancy=5; slot 2 is not consumed despite d_stall[2]=0.
- Fill to 14 of 16 → buf_ready=0 and the held group is ignored. Drain 1 → buf_ready=1 the next cycle. Run 20 groups across wrap and check that order is preserved.
- Enqueue group {ADD, WFI, ADD} → halted=1; only 2 entries are stored and buf_ready=0. After draining, squash → halted=0, occupancy=0, buf_ready=1.
- Squash together with enqueue and d_stall=000 on a non-empty buffer → dis_count=0 that cycle and occupancy=0 next cycle. With `DISPATCH_BUF_BYPASS_EN`, enqueue into empty with d_stall=000 → dis_count=3 in the same cycle and occupancy stays 0.
